// File: rtl/parking_slot_tracker_if.sv
// Parking slot tracker bus interface.
//   master : environment side (drives sensors and slot indices, observes results)
//   slave  : tracker side (parking_slot_tracker)
// Signals:
//   entry_sensor, exit_sensor : raw asynchronous car-present sensors
//   vacant_slot               : slot offered by the finder (0 = lot full)
//   exit_slot                 : slot being vacated
//   cars, occ_count           : registered occupancy vector and its population count
//   gate_open                 : entry gate-arm drive
//   entry_ack, entry_deny     : one-cycle entry result pulses
//   exit_ack, exit_err        : one-cycle exit result pulses
//   timeout                   : sticky gate-hold alarm (0 unless GATE_TIMEOUT_EN)
interface parking_slot_tracker_if;
    logic        entry_sensor;
    logic        exit_sensor;
    logic [3:0]  vacant_slot;
    logic [3:0]  exit_slot;
    logic [14:0] cars;
    logic [3:0]  occ_count;
    logic        gate_open;
    logic        entry_ack;
    logic        entry_deny;
    logic        exit_ack;
    logic        exit_err;
    logic        timeout;

    modport master (
        output entry_sensor, exit_sensor, vacant_slot, exit_slot,
        input  cars, occ_count, gate_open, entry_ack, entry_deny, exit_ack, exit_err, timeout
    );

    modport slave (
        input  entry_sensor, exit_sensor, vacant_slot, exit_slot,
        output cars, occ_count, gate_open, entry_ack, entry_deny, exit_ack, exit_err, timeout
    );
endinterface

// File: rtl/parking_slot_tracker.sv
// Parking slot tracker: write side of the parking occupancy vector.
// Synchronises and debounces the entry/exit car sensors, commits a car into the slot
// offered by the slot finder, releases a slot on exit and drives the entry gate-arm.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : parking_slot_tracker_if.slave (sensors, slot indices, occupancy, gate, pulses)
// Optional feature macro: GATE_TIMEOUT_EN
//   defined   : HOLD gives up after TIMEOUT_CYCLES with the car still present, closes
//               the gate and raises a sticky timeout alarm.
//   undefined : HOLD waits indefinitely, timeout is tied to 0.
module parking_slot_tracker #(
    parameter int unsigned N_SLOTS         = 15,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GATE_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    parking_slot_tracker_if.slave bus
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GC_W = $clog2(GATE_CYCLES + 1);

    // Slot encoding is 4 bits wide, so the slot count is not a free parameter.
    if (N_SLOTS != 15 || DEBOUNCE_CYCLES == 0 || GATE_CYCLES == 0 || TIMEOUT_CYCLES == 0)
    begin : g_param_check
        $error("parking_slot_tracker: unsupported parameter values");
    end

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCheck = 2'd1;
    localparam logic [1:0] StOpen  = 2'd2;
    localparam logic [1:0] StHold  = 2'd3;

    // Index 0 = entry sensor, index 1 = exit sensor.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            level_q, level_d;
    logic [1:0]            level_dly_q;
    logic [1:0]            rise_q;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    logic [1:0]            state_q, state_d;
    logic [GC_W-1:0]       gate_cnt_q, gate_cnt_d;
    logic                  gate_open_q, gate_open_d;
    logic [N_SLOTS-1:0]    cars_q, cars_d;
    logic [3:0]            occ_count_q, occ_count_d;
    logic                  entry_ack_q, entry_ack_d;
    logic                  entry_deny_q, entry_deny_d;
    logic                  exit_ack_q, exit_ack_d;
    logic                  exit_err_q, exit_err_d;
    logic [N_SLOTS-1:0]    entry_set;
    logic [N_SLOTS-1:0]    exit_clr;
    logic [N_SLOTS-1:0]    exit_mask;

`ifdef GATE_TIMEOUT_EN
    localparam int unsigned TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                  timeout_q, timeout_d;
`endif

    // Debounce: the level flips once DEBOUNCE_CYCLES consecutive synchronised samples
    // disagree with it; any agreeing sample restarts the count.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            rise_q      <= '0;
            db_cnt_q    <= '0;
        end else begin
            sync1_q     <= {bus.exit_sensor, bus.entry_sensor};
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
            db_cnt_q    <= db_cnt_d;
        end
    end

    // Entry FSM. vacant_slot is only looked at in CHECK, so the finder reacting to the
    // cars update cannot disturb the slot being committed.
    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        gate_open_d  = gate_open_q;
        entry_ack_d  = 1'b0;
        entry_deny_d = 1'b0;
        entry_set    = '0;
`ifdef GATE_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            StIdle: begin
                if (rise_q[0]) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (bus.vacant_slot == 4'd0 || occ_count_q == 4'(N_SLOTS)) begin
                    entry_deny_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    entry_set   = N_SLOTS'(1) << (bus.vacant_slot - 4'd1);
                    entry_ack_d = 1'b1;
                    gate_open_d = 1'b1;
                    gate_cnt_d  = GC_W'(GATE_CYCLES);
                    state_d     = StOpen;
                end
            end
            StOpen: begin
                gate_cnt_d = gate_cnt_q - 1'b1;
                if (gate_cnt_q == GC_W'(1)) begin
                    state_d = StHold;
`ifdef GATE_TIMEOUT_EN
                    tmo_cnt_d = TC_W'(TIMEOUT_CYCLES);
`endif
                end
            end
            StHold: begin
                if (!level_q[0]) begin
                    gate_open_d = 1'b0;
                    state_d     = StIdle;
`ifdef GATE_TIMEOUT_EN
                end else if (tmo_cnt_q == TC_W'(1)) begin
                    // Car still sensed: force the arm down, keep the slot occupied.
                    gate_open_d = 1'b0;
                    timeout_d   = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Exit path, independent of the FSM. A zero index shifts the mask out entirely.
    always_comb begin
        exit_ack_d = 1'b0;
        exit_err_d = 1'b0;
        exit_clr   = '0;
        exit_mask  = N_SLOTS'(1) << (bus.exit_slot - 4'd1);
        if (rise_q[1]) begin
            if (bus.exit_slot != 4'd0 && (cars_q & exit_mask) != '0) begin
                exit_clr   = exit_mask;
                exit_ack_d = 1'b1;
            end else begin
                exit_err_d = 1'b1;
            end
        end
    end

    // Entry targets a free slot and exit an occupied one, so both can apply together.
    always_comb begin
        cars_d      = (cars_q | entry_set) & ~exit_clr;
        occ_count_d = occ_count_q + 4'(entry_ack_d) - 4'(exit_ack_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gate_cnt_q   <= '0;
            gate_open_q  <= 1'b0;
            cars_q       <= '0;
            occ_count_q  <= '0;
            entry_ack_q  <= 1'b0;
            entry_deny_q <= 1'b0;
            exit_ack_q   <= 1'b0;
            exit_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            gate_open_q  <= gate_open_d;
            cars_q       <= cars_d;
            occ_count_q  <= occ_count_d;
            entry_ack_q  <= entry_ack_d;
            entry_deny_q <= entry_deny_d;
            exit_ack_q   <= exit_ack_d;
            exit_err_q   <= exit_err_d;
        end
    end

`ifdef GATE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.cars       = cars_q;
    assign bus.occ_count  = occ_count_q;
    assign bus.gate_open  = gate_open_q;
    assign bus.entry_ack  = entry_ack_q;
    assign bus.entry_deny = entry_deny_q;
    assign bus.exit_ack   = exit_ack_q;
    assign bus.exit_err   = exit_err_q;

endmodule

// File: tb/tb_parking_slot_tracker.sv
module tb_parking_slot_tracker;

    logic clk;
    logic rst_n;

    parking_slot_tracker_if bus ();

    parking_slot_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks = 0;
    int pass_checks  = 0;

    // Pulse/gate monitor, sampled on the falling edge.
    int entry_ack_cnt, entry_deny_cnt, exit_ack_cnt, exit_err_cnt, both_ack_cnt;
    int gate_run, gate_max;
    bit timeout_seen;

    always @(negedge clk) begin
        if (bus.entry_ack)  entry_ack_cnt++;
        if (bus.entry_deny) entry_deny_cnt++;
        if (bus.exit_ack)   exit_ack_cnt++;
        if (bus.exit_err)   exit_err_cnt++;
        if (bus.entry_ack && bus.exit_ack) both_ack_cnt++;
        if (bus.timeout)    timeout_seen = 1'b1;
        if (bus.gate_open) begin
            gate_run++;
            if (gate_run > gate_max) gate_max = gate_run;
        end else begin
            gate_run = 0;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total_checks++;
        if (got == exp) begin
            pass_checks++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Cleared just after a rising edge so it never races the negedge monitor.
    task automatic clear_mon();
        @(posedge clk);
        #1;
        entry_ack_cnt  = 0;
        entry_deny_cnt = 0;
        exit_ack_cnt   = 0;
        exit_err_cnt   = 0;
        both_ack_cnt   = 0;
        gate_run       = 0;
        gate_max       = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          is_exit;
        int          hold;
        logic [3:0]  slot;
        int          exp_ack;
        int          exp_rej;
        logic [14:0] exp_cars;
        int          exp_cnt;
    } op_t;

    op_t ops[$];

    task automatic run_op(input op_t op, input int idx);
        int close_at;
        string tag;
        tag = $sformatf("op%0d", idx);
        clear_mon();
        @(negedge clk);
        if (op.is_exit) begin
            bus.exit_slot   = op.slot;
            bus.exit_sensor = 1'b1;
        end else begin
            bus.vacant_slot  = op.slot;
            bus.entry_sensor = 1'b1;
        end
        repeat (op.hold) @(negedge clk);
        bus.exit_sensor  = 1'b0;
        bus.entry_sensor = 1'b0;
        // Gate should drop 2 sync + DEBOUNCE_CYCLES + 1 edges after the sensor falls.
        close_at = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!bus.gate_open) begin
                close_at = i;
                break;
            end
        end
        repeat (15) @(negedge clk);
        if (op.is_exit) begin
            check({tag, "_exit_ack"}, exit_ack_cnt, op.exp_ack);
            check({tag, "_exit_err"}, exit_err_cnt, op.exp_rej);
            check({tag, "_entry_none"}, entry_ack_cnt + entry_deny_cnt, 0);
        end else begin
            check({tag, "_entry_ack"}, entry_ack_cnt, op.exp_ack);
            check({tag, "_entry_deny"}, entry_deny_cnt, op.exp_rej);
            check({tag, "_exit_none"}, exit_ack_cnt + exit_err_cnt, 0);
            check({tag, "_gate_len"}, (gate_max >= 8) ? 8 : gate_max, (op.exp_ack != 0) ? 8 : 0);
            check({tag, "_gate_close"}, close_at, (op.exp_ack != 0) ? 7 : 1);
        end
        check({tag, "_cars"}, int'(bus.cars), int'(op.exp_cars));
        check({tag, "_occ"}, int'(bus.occ_count), op.exp_cnt);
    endtask

    function automatic op_t mk(input bit is_exit, input int hold, input logic [3:0] slot,
                               input int ack, input int rej, input logic [14:0] c,
                               input int n);
        op_t o;
        o.is_exit  = is_exit;
        o.hold     = hold;
        o.slot     = slot;
        o.exp_ack  = ack;
        o.exp_rej  = rej;
        o.exp_cars = c;
        o.exp_cnt  = n;
        return o;
    endfunction

    initial begin
        int found;
        int close_cnt;
        logic [14:0] full_mask;

        rst_n            = 1'b0;
        bus.entry_sensor = 1'b0;
        bus.exit_sensor  = 1'b0;
        bus.vacant_slot  = 4'd0;
        bus.exit_slot    = 4'd0;
        timeout_seen     = 1'b0;
        entry_ack_cnt    = 0;
        entry_deny_cnt   = 0;
        exit_ack_cnt     = 0;
        exit_err_cnt     = 0;
        both_ack_cnt     = 0;
        gate_run         = 0;
        gate_max         = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cars", int'(bus.cars), 0);
        check("rst_occ", int'(bus.occ_count), 0);
        check("rst_gate", int'(bus.gate_open), 0);
        check("rst_pulses", int'({bus.entry_ack, bus.entry_deny, bus.exit_ack, bus.exit_err}), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        rst_n = 1'b1;

        // Phase 1: glitch, two entries, exit, repeated exit, zero exit.
        ops.push_back(mk(0, 2,  4'd3, 0, 0, 15'h0000, 0));
        ops.push_back(mk(0, 20, 4'd3, 1, 0, 15'h0004, 1));
        ops.push_back(mk(0, 20, 4'd1, 1, 0, 15'h0005, 2));
        ops.push_back(mk(1, 10, 4'd3, 1, 0, 15'h0001, 1));
        ops.push_back(mk(1, 10, 4'd3, 0, 1, 15'h0001, 1));
        ops.push_back(mk(1, 10, 4'd0, 0, 1, 15'h0001, 1));
        foreach (ops[i]) run_op(ops[i], i);

        // Simultaneous entry commit (slot 2) and exit commit (slot 1): the exit sensor
        // rises one cycle after the entry sensor so its event lands while the FSM is in CHECK.
        clear_mon();
        @(negedge clk);
        bus.vacant_slot  = 4'd2;
        bus.exit_slot    = 4'd1;
        bus.entry_sensor = 1'b1;
        @(negedge clk);
        bus.exit_sensor  = 1'b1;
        repeat (20) @(negedge clk);
        bus.entry_sensor = 1'b0;
        bus.exit_sensor  = 1'b0;
        repeat (20) @(negedge clk);
        check("simul_both", both_ack_cnt, 1);
        check("simul_entry_ack", entry_ack_cnt, 1);
        check("simul_exit_ack", exit_ack_cnt, 1);
        check("simul_cars", int'(bus.cars), 32'h0002);
        check("simul_occ", int'(bus.occ_count), 1);

        do_reset();
        check("rst2_cars", int'(bus.cars), 0);
        check("rst2_occ", int'(bus.occ_count), 0);

        // Phase 2: fill every slot, then a zero offer and an offer while full.
        ops.delete();
        full_mask = '0;
        for (int s = 1; s <= 15; s++) begin
            full_mask[s-1] = 1'b1;
            ops.push_back(mk(0, 20, 4'(s), 1, 0, full_mask, s));
        end
        ops.push_back(mk(0, 20, 4'd0, 0, 1, 15'h7FFF, 15));
        ops.push_back(mk(0, 20, 4'd5, 0, 1, 15'h7FFF, 15));
        foreach (ops[i]) run_op(ops[i], 100 + i);

        // Reset asserted while the gate is in OPEN clears everything without a clock edge.
        do_reset();
        clear_mon();
        @(negedge clk);
        bus.vacant_slot  = 4'd4;
        bus.entry_sensor = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.entry_ack) begin
                found = 1;
                break;
            end
        end
        check("mid_open_ack", found, 1);
        repeat (3) @(negedge clk);
        check("mid_open_gate_before", int'(bus.gate_open), 1);
        check("mid_open_cars_before", int'(bus.cars), 32'h0008);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_open_gate_async", int'(bus.gate_open), 0);
        check("mid_open_cars_async", int'(bus.cars), 0);
        check("mid_open_occ_async", int'(bus.occ_count), 0);
        bus.entry_sensor = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_open_after_cars", int'(bus.cars), 0);

`ifdef GATE_TIMEOUT_EN
        // Sensor held high: gate forced shut 8+64 cycles after the commit.
        do_reset();
        @(negedge clk);
        bus.vacant_slot  = 4'd6;
        bus.entry_sensor = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.entry_ack) begin
                found = 1;
                break;
            end
        end
        check("tmo_ack", found, 1);
        close_cnt = 0;
        for (int j = 1; j <= 150; j++) begin
            @(negedge clk);
            if (!bus.gate_open) begin
                close_cnt = j;
                break;
            end
        end
        check("tmo_close_cycles", close_cnt, 72);
        check("tmo_flag", int'(bus.timeout), 1);
        check("tmo_cars", int'(bus.cars), 32'h0020);
        repeat (30) @(negedge clk);
        bus.entry_sensor = 1'b0;
        repeat (20) @(negedge clk);
        check("tmo_sticky", int'(bus.timeout), 1);
        check("tmo_gate_shut", int'(bus.gate_open), 0);
        do_reset();
        check("tmo_cleared", int'(bus.timeout), 0);
`else
        check("no_timeout_ever", int'(timeout_seen), 0);
`endif

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
